// File: rtl/trivium_stream.sv
// Trivium keystream generator with WORD_W bits per clock, a valid/ready output stream
// and a run-time key/IV load port that restarts the warm-up phase.
module trivium_stream #(
    parameter int unsigned WORD_W      = 8,
    parameter int unsigned INIT_ROUNDS = 1152,
    parameter logic [79:0] DEFAULT_KEY = 80'h9719CFC92A9FF688F9AA,
    parameter logic [79:0] DEFAULT_IV  = 80'hECBB76B09AFF71D0D151
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_valid,
    output logic              load_ready,
    input  logic [79:0]       key_in,
    input  logic [79:0]       iv_in,
    output logic              ks_valid,
    input  logic              ks_ready,
    output logic [WORD_W-1:0] ks_data,
    output logic              busy
);
    localparam int unsigned STATE_W    = 288;
    localparam int unsigned INIT_WORDS = INIT_ROUNDS / WORD_W;
    localparam int unsigned CNT_W      = (INIT_WORDS < 1) ? 1 : $clog2(INIT_WORDS + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(INIT_WORDS - 1);

    if (!(WORD_W == 1 || WORD_W == 2 || WORD_W == 4 || WORD_W == 8 ||
          WORD_W == 16 || WORD_W == 32 || WORD_W == 64)) begin : g_bad_word_w
        $error("trivium_stream: WORD_W must be one of 1, 2, 4, 8, 16, 32, 64");
    end
    if (INIT_ROUNDS == 0 || (INIT_ROUNDS % WORD_W) != 0) begin : g_bad_init_rounds
        $error("trivium_stream: INIT_ROUNDS must be a nonzero multiple of WORD_W");
    end

    // Bit k of the packed state holds Trivium cell s(k+1).
    function automatic logic [STATE_W-1:0] load_state(input logic [79:0] key,
                                                      input logic [79:0] iv);
        logic [STATE_W-1:0] s;
        s = '0;
        for (int i = 0; i < 80; i++) begin
            s[i]      = key[79-i];
            s[93+i]   = iv[79-i];
        end
        s[287:285] = 3'b111;
        return s;
    endfunction

    function automatic logic step_z(input logic [STATE_W-1:0] s);
        return s[65] ^ s[92] ^ s[161] ^ s[176] ^ s[242] ^ s[287];
    endfunction

    function automatic logic [STATE_W-1:0] step_s(input logic [STATE_W-1:0] s);
        logic t1, t2, t3;
        t1 = s[65] ^ s[92] ^ (s[90] & s[91]) ^ s[170];
        t2 = s[161] ^ s[176] ^ (s[174] & s[175]) ^ s[263];
        t3 = s[242] ^ s[287] ^ (s[285] & s[286]) ^ s[68];
        return {s[286:177], t2, s[175:93], t1, s[91:0], t3};
    endfunction

    localparam logic [STATE_W-1:0] RESET_STATE = load_state(DEFAULT_KEY, DEFAULT_IV);

    typedef enum logic {INIT, RUN} state_e;

    state_e             state_q, state_d;
    logic [STATE_W-1:0] s_q, s_d, s_adv;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ks_valid_q, ks_valid_d;
    logic [WORD_W-1:0]  ks_data_q, ks_data_d, z_word;
    logic               busy_q, busy_d;
    logic               load_ready_q, load_ready_d;
    logic               load_acc, slot_free;

    // WORD_W single-bit steps unrolled; bit j of the word is the output of step j.
    always_comb begin
        s_adv  = s_q;
        z_word = '0;
        for (int j = 0; j < WORD_W; j++) begin
            z_word[j] = step_z(s_adv);
            s_adv     = step_s(s_adv);
        end
    end

    always_comb begin
        state_d    = state_q;
        s_d        = s_q;
        cnt_d      = cnt_q;
        ks_valid_d = ks_valid_q;
        ks_data_d  = ks_data_q;
        load_acc   = load_valid && load_ready_q;
        slot_free  = !ks_valid_q || ks_ready;
        case (state_q)
            INIT: begin
                s_d   = s_adv;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                // A reload wins over output generation and drops any pending word.
                if (load_acc) begin
                    s_d        = load_state(key_in, iv_in);
                    cnt_d      = '0;
                    state_d    = INIT;
                    ks_valid_d = 1'b0;
                end else if (slot_free) begin
                    ks_data_d  = z_word;
                    s_d        = s_adv;
                    ks_valid_d = 1'b1;
                end
            end
            default: state_d = INIT;
        endcase
        busy_d       = (state_d == INIT);
        load_ready_d = (state_d == RUN);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= INIT;
            s_q          <= RESET_STATE;
            cnt_q        <= '0;
            ks_valid_q   <= 1'b0;
            ks_data_q    <= '0;
            busy_q       <= 1'b1;
            load_ready_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            s_q          <= s_d;
            cnt_q        <= cnt_d;
            ks_valid_q   <= ks_valid_d;
            ks_data_q    <= ks_data_d;
            busy_q       <= busy_d;
            load_ready_q <= load_ready_d;
        end
    end

    assign ks_valid   = ks_valid_q;
    assign ks_data    = ks_data_q;
    assign busy       = busy_q;
    assign load_ready = load_ready_q;

endmodule
